// File: rtl/e_reg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | e_reg_pkg : shared opcode definitions and NOP field values       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package e_reg_pkg;

  localparam logic [5:0] IROP  = 6'h00;
  localparam logic [5:0] IJ    = 6'h02;
  localparam logic [5:0] IADDI = 6'h08;
  localparam logic [5:0] IANDI = 6'h0C;
  localparam logic [5:0] IORI  = 6'h0D;
  localparam logic [5:0] ILW   = 6'h23;
  localparam logic [5:0] ISW   = 6'h2B;

  // A bubble is an R-type with func 0 writing r0, marked invalid.
  localparam logic [5:0] c_nopOp    = IROP;
  localparam logic [5:0] c_nopFunc  = 6'h00;
  localparam logic [4:0] c_nopDst   = 5'd0;
  localparam logic       c_nopValid = 1'b0;

  function automatic logic isLoad(input logic [5:0] op);
    return op == ILW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_reg_load_use_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_use_det : flags a decode source that needs a load in E      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module load_use_det
  import e_reg_pkg::*;
(
  input  logic [5:0] E_op,
  input  logic [4:0] E_dstE,
  input  logic       E_valid,
  input  logic [4:0] D_srcA,
  input  logic [4:0] D_srcB,
  input  logic       D_valid,
  output logic       d_stall
);

  logic w_srcMatch;

  assign w_srcMatch = (E_dstE == D_srcA) || (E_dstE == D_srcB);
  // r0 is never a real dependency, so a load into r0 does not stall.
  assign d_stall = E_valid && isLoad(E_op) && (E_dstE != 5'd0) &&
                   D_valid && w_srcMatch;

endmodule
`default_nettype wire

// File: rtl/e_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | e_reg : decode-to-execute pipeline register with load-use bubble |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module e_reg
  import e_reg_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_CNT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        D_op,
  input  logic [5:0]        D_func,
  input  logic [W_DATA-1:0] D_valA,
  input  logic [W_DATA-1:0] D_valB,
  input  logic [W_DATA-1:0] D_valC,
  input  logic [4:0]        D_srcA,
  input  logic [4:0]        D_srcB,
  input  logic [4:0]        D_dstE,
  input  logic              D_valid,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [5:0]        E_op,
  output logic [5:0]        E_func,
  output logic [W_DATA-1:0] E_valA,
  output logic [W_DATA-1:0] E_valB,
  output logic [W_DATA-1:0] E_valC,
  output logic [4:0]        E_dstE,
  output logic              E_valid,
  output logic              d_stall,
  output logic [W_CNT-1:0]  bubble_cnt
);

  logic [5:0]        r_op;
  logic [5:0]        r_func;
  logic [W_DATA-1:0] r_valA;
  logic [W_DATA-1:0] r_valB;
  logic [W_DATA-1:0] r_valC;
  logic [4:0]        r_dstE;
  logic              r_valid;
  logic [W_CNT-1:0]  r_bubbleCnt;
  logic              w_dStall;

  load_use_det u_loadUseDet (
    .E_op    (r_op),
    .E_dstE  (r_dstE),
    .E_valid (r_valid),
    .D_srcA  (D_srcA),
    .D_srcB  (D_srcB),
    .D_valid (D_valid),
    .d_stall (w_dStall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= c_nopOp;
      r_func      <= c_nopFunc;
      r_valA      <= '0;
      r_valB      <= '0;
      r_valC      <= '0;
      r_dstE      <= c_nopDst;
      r_valid     <= c_nopValid;
      r_bubbleCnt <= '0;
    end else if (!E_stall) begin
      if (E_bubble || w_dStall) begin
        r_op    <= c_nopOp;
        r_func  <= c_nopFunc;
        r_valA  <= '0;
        r_valB  <= '0;
        r_valC  <= '0;
        r_dstE  <= c_nopDst;
        r_valid <= c_nopValid;
        if (r_bubbleCnt != '1) r_bubbleCnt <= r_bubbleCnt + W_CNT'(1);
      end else begin
        r_op    <= D_op;
        r_func  <= D_func;
        r_valA  <= D_valA;
        r_valB  <= D_valB;
        r_valC  <= D_valC;
        // An empty decode slot must never claim a destination register.
        r_dstE  <= D_valid ? D_dstE : 5'd0;
        r_valid <= D_valid;
      end
    end
  end

  assign E_op       = r_op;
  assign E_func     = r_func;
  assign E_valA     = r_valA;
  assign E_valB     = r_valB;
  assign E_valC     = r_valC;
  assign E_dstE     = r_dstE;
  assign E_valid    = r_valid;
  assign d_stall    = w_dStall;
  assign bubble_cnt = r_bubbleCnt;

endmodule
`default_nettype wire
